// File: rtl/skinny_round_ctrl_if.sv
// Handshake/status bundle between the SKINNY round sequencer and its user.
// The master drives start (and abort when SKINNY_CTRL_ABORT_EN is defined);
// the slave is skinny_round_ctrl.
interface skinny_round_ctrl_if #(
    parameter int unsigned RCW = 6
) ();
    logic           start;
`ifdef SKINNY_CTRL_ABORT_EN
    logic           abort;
`endif
    logic           sel;
    logic           en_state;
    logic           en_key;
    logic           rand_en;
    logic [RCW-1:0] round_cnt;
    logic           last_round;
    logic           busy;
    logic           done;

`ifdef SKINNY_CTRL_ABORT_EN
    modport master (
        output start, abort,
        input  sel, en_state, en_key, rand_en, round_cnt, last_round, busy, done
    );
    modport slave (
        input  start, abort,
        output sel, en_state, en_key, rand_en, round_cnt, last_round, busy, done
    );
`else
    modport master (
        output start,
        input  sel, en_state, en_key, rand_en, round_cnt, last_round, busy, done
    );
    modport slave (
        input  start,
        output sel, en_state, en_key, rand_en, round_cnt, last_round, busy, done
    );
`endif
endinterface

// File: rtl/skinny_round_ctrl.sv
// Round sequencer for the masked SKINNY core: drives the bank select and capture
// enables of the state/tweakey flip-flop banks, counting S-box pipeline stages per
// round and rounds per encryption. All outputs are registered.
// Optional feature macro: SKINNY_CTRL_ABORT_EN (adds bus.abort to cancel a run).
module skinny_round_ctrl #(
    parameter int unsigned NR_ROUNDS = 40,
    parameter int unsigned STAGES    = 3,
    parameter int unsigned RCW       = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    skinny_round_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StRound, StDone} state_e;

    localparam int unsigned    SCW       = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [SCW-1:0] StageLast = SCW'(STAGES - 1);
    localparam logic [RCW-1:0] RoundLast = RCW'(NR_ROUNDS - 1);
    // With a single stage per round every ROUND cycle is a capture cycle.
    localparam logic           EnAtWrap  = (STAGES == 1);
    localparam logic           OneRound  = (NR_ROUNDS == 1);

    state_e         state_q;
    logic [SCW-1:0] stage_q;
    logic [RCW-1:0] round_q;
    logic           sel_q;
    logic           en_q;
    logic           rand_q;
    logic           last_q;
    logic           busy_q;
    logic           done_q;

    logic           stage_end;
    logic           round_end;
    logic [SCW-1:0] stage_inc;
    logic [RCW-1:0] round_inc;
    logic           abort_hit;

    assign stage_end = (stage_q == StageLast);
    assign round_end = (round_q == RoundLast);
    assign stage_inc = stage_q + SCW'(1);
    assign round_inc = round_q + RCW'(1);

`ifdef SKINNY_CTRL_ABORT_EN
    // Abort only matters while an encryption is in flight.
    assign abort_hit = bus.abort && ((state_q == StLoad) || (state_q == StRound));
`else
    assign abort_hit = 1'b0;
`endif

    // FSM, counters and registered outputs; outputs are loaded for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            stage_q <= '0;
            round_q <= '0;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            rand_q  <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Idle-style outputs unless the branch below enters LOAD/ROUND/DONE.
            sel_q  <= 1'b0;
            en_q   <= 1'b0;
            rand_q <= 1'b0;
            last_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            if (abort_hit) begin
                state_q <= StIdle;
                stage_q <= '0;
                round_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.start) begin
                            state_q <= StLoad;
                            en_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    StLoad: begin
                        state_q <= StRound;
                        stage_q <= '0;
                        round_q <= '0;
                        sel_q   <= 1'b1;
                        rand_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        en_q    <= EnAtWrap;
                        last_q  <= OneRound;
                    end
                    StRound: begin
                        if (stage_end) begin
                            stage_q <= '0;
                            if (round_end) begin
                                state_q <= StDone;
                                round_q <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                round_q <= round_inc;
                                sel_q   <= 1'b1;
                                rand_q  <= 1'b1;
                                busy_q  <= 1'b1;
                                en_q    <= EnAtWrap;
                                last_q  <= (round_inc == RoundLast);
                            end
                        end else begin
                            stage_q <= stage_inc;
                            sel_q   <= 1'b1;
                            rand_q  <= 1'b1;
                            busy_q  <= 1'b1;
                            en_q    <= (stage_inc == StageLast);
                            last_q  <= round_end;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.sel        = sel_q;
    assign bus.en_state   = en_q;
    assign bus.en_key     = en_q;
    assign bus.rand_en    = rand_q;
    assign bus.round_cnt  = round_q;
    assign bus.last_round = last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Directed bench for skinny_round_ctrl: a default 40x3 instance and a 4x1 instance.
module tb_skinny_round_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   en_cnt;
    int   sel0_cnt;

    always #5 clk = ~clk;

    skinny_round_ctrl_if #(.RCW(6)) bus_a ();
    skinny_round_ctrl_if #(.RCW(6)) bus_b ();

    skinny_round_ctrl #(.NR_ROUNDS(40), .STAGES(3), .RCW(6)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    skinny_round_ctrl #(.NR_ROUNDS(4), .STAGES(1), .RCW(6)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {sel,en_state,en_key,rand_en,last_round,busy,done,round_cnt[5:0]} in cycle c,
    // where start was sampled at the edge ending cycle 0.
    function automatic logic [12:0] exp_vec(input int c, input int stages, input int nr);
        int k;
        logic [5:0] rc;
        logic en;
        logic last;
        if (c == 1) return {7'b0110010, 6'd0};
        if (c >= 2 && c <= 1 + nr * stages) begin
            k    = c - 2;
            rc   = 6'(k / stages);
            en   = ((k % stages) == stages - 1);
            last = ((k / stages) == nr - 1);
            return {1'b1, en, en, 1'b1, last, 1'b1, 1'b0, rc};
        end
        if (c == 2 + nr * stages) return {7'b0000001, 6'd0};
        return 13'd0;
    endfunction

    function automatic logic [12:0] obs_a();
        return {bus_a.sel, bus_a.en_state, bus_a.en_key, bus_a.rand_en, bus_a.last_round,
                bus_a.busy, bus_a.done, bus_a.round_cnt};
    endfunction

    function automatic logic [12:0] obs_b();
        return {bus_b.sel, bus_b.en_state, bus_b.en_key, bus_b.rand_en, bus_b.last_round,
                bus_b.busy, bus_b.done, bus_b.round_cnt};
    endfunction

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
`ifdef SKINNY_CTRL_ABORT_EN
        bus_a.abort = 1'b0;
        bus_b.abort = 1'b0;
`endif
        // Reset state
        repeat (2) tick();
        check_eq("reset_a", 32'(obs_a()), 32'd0);
        check_eq("reset_b", 32'(obs_b()), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_a", 32'(obs_a()), 32'd0);

        // Single start pulse: full 40-round run
        tick();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        en_cnt   = 0;
        sel0_cnt = 0;
        for (int c = 1; c <= 124; c++) begin
            if (c > 1) tick();
            check_eq($sformatf("run1_c%0d", c), 32'(obs_a()), 32'(exp_vec(c, 3, 40)));
            if (bus_a.en_state) en_cnt++;
            if (bus_a.busy && !bus_a.sel) sel0_cnt++;
        end
        check_eq("run1_en_pulses", 32'(en_cnt), 32'd41);
        check_eq("run1_sel0_pulses", 32'(sel0_cnt), 32'd1);

        // start held high for 200 cycles: back-to-back runs, second LOAD at 124
        tick();
        bus_a.start = 1'b1;
        en_cnt = 0;
        for (int c = 1; c <= 250; c++) begin
            tick();
            if (c == 200) bus_a.start = 1'b0;
            check_eq($sformatf("held_c%0d", c), 32'(obs_a()),
                     32'((c <= 123) ? exp_vec(c, 3, 40) : exp_vec(c - 123, 3, 40)));
            if (c <= 122 && bus_a.en_state) en_cnt++;
        end
        check_eq("held_first_en_pulses", 32'(en_cnt), 32'd41);

        // Asynchronous reset at cycle 50, then restart
        tick();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (c > 1) tick();
            check_eq($sformatf("prerst_c%0d", c), 32'(obs_a()), 32'(exp_vec(c, 3, 40)));
        end
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_a", 32'(obs_a()), 32'd0);
        check_eq("async_rst_b", 32'(obs_b()), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check_eq($sformatf("postrst_c%0d", c), 32'(obs_a()), 32'd0);
            tick();
        end
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int c = 1; c <= 123; c++) begin
            if (c > 1) tick();
            check_eq($sformatf("restart_c%0d", c), 32'(obs_a()), 32'(exp_vec(c, 3, 40)));
        end

        // STAGES=1, NR_ROUNDS=4 instance
        tick();
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick();
            check_eq($sformatf("small_c%0d", c), 32'(obs_b()), 32'(exp_vec(c, 1, 4)));
        end

`ifdef SKINNY_CTRL_ABORT_EN
        // Abort at cycle 60, restart at 65
        tick();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) tick();
            check_eq($sformatf("preabort_c%0d", c), 32'(obs_a()), 32'(exp_vec(c, 3, 40)));
        end
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        check_eq("abort_idle_c61", 32'(obs_a()), 32'd0);
        for (int c = 62; c <= 65; c++) begin
            tick();
            check_eq($sformatf("abort_idle_c%0d", c), 32'(obs_a()), 32'd0);
        end
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int c = 66; c <= 188; c++) begin
            if (c > 66) tick();
            check_eq($sformatf("postabort_c%0d", c), 32'(obs_a()), 32'(exp_vec(c - 65, 3, 40)));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
